// File: rtl/boot_source_sel_pkg.sv
// Shared constants and types for the boot-source selector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package boot_source_sel_pkg;

    // Selector state encoding; the values are visible on the state port.
    typedef enum logic [1:0] {
        ST_BIOS       = 2'd0,
        ST_PULSE_MEM  = 2'd1,
        ST_MEMORY     = 2'd2,
        ST_PULSE_BIOS = 2'd3
    } boot_state_t;

    // Width of the reset-pulse counter.
    localparam int CNT_W = 8;

    // Default opcode field position and the opcode that ends BIOS execution.
    localparam int         DEF_OPCODE_MSB  = 31;
    localparam int         DEF_OPCODE_LSB  = 26;
    localparam logic [5:0] DEF_HALT_OPCODE = 6'b011101;

endpackage

// File: rtl/boot_source_sel_pulse_counter.sv
// Load/decrement counter with zero flag, used to time the core reset pulse.
// Latency: load/decrement visible one cycle after the edge; zero flag is combinational.
// Backpressure: none; load has priority over decrement.
module pulse_counter
    import boot_source_sel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Counter register: reset clears, load wins over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/boot_source_sel.sv
// Selects BIOS ROM or main memory for fetch; HALT from BIOS triggers a core reset pulse and handoff.
// Latency: state/core_rst/handoff_done registered (1 cycle); mux_output combinational from state.
// Backpressure: none; inputs are sampled every cycle, HALT and bios_req are ignored while pulsing.
module boot_source_sel
    import boot_source_sel_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int OPCODE_MSB       = DEF_OPCODE_MSB,
    parameter int OPCODE_LSB       = DEF_OPCODE_LSB,
    parameter logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = DEF_HALT_OPCODE,
    parameter int RST_PULSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  handoff_en,
    input  logic                  bios_req,
    input  logic                  instr_valid,
    input  logic [DATA_WIDTH-1:0] input_data_1,
    input  logic [DATA_WIDTH-1:0] input_data_2,
    output logic [DATA_WIDTH-1:0] mux_output,
    output logic                  core_rst,
    output logic [1:0]            state,
    output logic                  handoff_done
);

    // Counter is loaded with length-1 so that the zero cycle is the last pulse cycle.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(RST_PULSE_CYCLES - 1);

    boot_state_t                    state_q;
    boot_state_t                    state_d;
    logic                           cnt_load;
    logic                           cnt_dec;
    logic                           cnt_zero;
    logic [CNT_W-1:0]               cnt;
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic                           halt_hit;

    assign opcode   = input_data_1[OPCODE_MSB:OPCODE_LSB];
    assign halt_hit = instr_valid && handoff_en && (opcode == HALT_OPCODE);

    pulse_counter u_pulse_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (PULSE_LOAD),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Next-state and counter control.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_BIOS: begin
                if (halt_hit) begin
                    state_d  = ST_PULSE_MEM;
                    cnt_load = 1'b1;
                end
            end
            ST_PULSE_MEM: begin
                if (cnt_zero) begin
                    state_d = ST_MEMORY;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_MEMORY: begin
                if (bios_req) begin
                    state_d  = ST_PULSE_BIOS;
                    cnt_load = 1'b1;
                end
            end
            ST_PULSE_BIOS: begin
                if (cnt_zero) begin
                    state_d = ST_BIOS;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_BIOS;
            end
        endcase
    end

    // State and registered outputs; core_rst follows the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BIOS;
            core_rst     <= 1'b0;
            handoff_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_rst     <= (state_d == ST_PULSE_MEM) || (state_d == ST_PULSE_BIOS);
            handoff_done <= (state_q == ST_PULSE_MEM) && (state_d == ST_MEMORY);
        end
    end

    assign state = state_q;

    // Fetch source: main memory only in PULSE_MEM and MEMORY.
    always_comb begin
        mux_output = input_data_1;
        if ((state_q == ST_PULSE_MEM) || (state_q == ST_MEMORY)) begin
            mux_output = input_data_2;
        end
    end

endmodule

// File: tb/tb_boot_source_sel.sv
// Bench for boot_source_sel: two builds (pulse length 4 and 1) share stimulus.
// Each is compared every cycle against a side/remaining-pulse reference model.
// Directed sequence first, then randomized traffic.
module tb_boot_source_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic        handoff_en;
    logic        bios_req;
    logic        instr_valid;
    logic [31:0] input_data_1;
    logic [31:0] input_data_2;

    logic [31:0] mux4, mux1;
    logic        crst4, crst1;
    logic [1:0]  st4, st1;
    logic        hd4, hd1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: which side fetch belongs to, and how many reset cycles remain.
    int pulse_len [2] = '{4, 1};
    bit m_mem     [2];
    int m_left    [2];
    bit m_hd      [2];

    always #5 clk = ~clk;

    boot_source_sel #(.RST_PULSE_CYCLES(4)) u_p4 (
        .clk(clk), .rst(rst), .handoff_en(handoff_en), .bios_req(bios_req),
        .instr_valid(instr_valid), .input_data_1(input_data_1), .input_data_2(input_data_2),
        .mux_output(mux4), .core_rst(crst4), .state(st4), .handoff_done(hd4)
    );

    boot_source_sel #(.RST_PULSE_CYCLES(1)) u_p1 (
        .clk(clk), .rst(rst), .handoff_en(handoff_en), .bios_req(bios_req),
        .instr_valid(instr_valid), .input_data_1(input_data_1), .input_data_2(input_data_2),
        .mux_output(mux1), .core_rst(crst1), .state(st1), .handoff_done(hd1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int k);
        logic [31:0] w;
        w = input_data_1;
        m_hd[k] = 1'b0;
        if (rst) begin
            m_mem[k]  = 1'b0;
            m_left[k] = 0;
        end else if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 0 && m_mem[k]) m_hd[k] = 1'b1;
        end else if (!m_mem[k]) begin
            if (instr_valid && handoff_en && w[31:26] == 6'b011101) begin
                m_mem[k]  = 1'b1;
                m_left[k] = pulse_len[k];
            end
        end else if (bios_req) begin
            m_mem[k]  = 1'b0;
            m_left[k] = pulse_len[k];
        end
    endtask

    task automatic step();
        logic [1:0]  exp_st;
        logic [31:0] exp_mux;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (m_left[k] > 0) exp_st = m_mem[k] ? 2'd1 : 2'd3;
            else               exp_st = m_mem[k] ? 2'd2 : 2'd0;
            exp_mux = m_mem[k] ? input_data_2 : input_data_1;
            check(k == 0 ? "p4.state"    : "p1.state",    {30'd0, (k == 0 ? st4 : st1)}, {30'd0, exp_st});
            check(k == 0 ? "p4.core_rst" : "p1.core_rst", {31'd0, (k == 0 ? crst4 : crst1)}, {31'd0, m_left[k] > 0});
            check(k == 0 ? "p4.handoff"  : "p1.handoff",  {31'd0, (k == 0 ? hd4 : hd1)}, {31'd0, m_hd[k]});
            check(k == 0 ? "p4.mux"      : "p1.mux",      (k == 0 ? mux4 : mux1), exp_mux);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic req, input logic v,
                         input logic [5:0] opc);
        rst          = r;
        handoff_en   = en;
        bios_req     = req;
        instr_valid  = v;
        input_data_1 = {opc, 26'($urandom)};
        input_data_2 = $urandom;
        step();
    endtask

    localparam logic [5:0] HALT = 6'b011101;
    localparam logic [5:0] NOP  = 6'b000000;

    initial begin
        logic [5:0] opc;
        for (int k = 0; k < 2; k++) begin
            m_mem[k] = 1'b0; m_left[k] = 0; m_hd[k] = 1'b0;
        end

        // Reset, then plain BIOS words.
        drive(1, 1, 0, 1, NOP);
        drive(1, 1, 0, 1, NOP);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, NOP);

        // HALT not qualified: handoff disabled, then instr_valid low.
        drive(0, 0, 0, 1, HALT);
        drive(0, 0, 0, 1, HALT);
        drive(0, 1, 0, 0, HALT);
        drive(0, 1, 0, 0, HALT);
        // bios_req while in BIOS is ignored.
        drive(0, 1, 1, 0, NOP);

        // Qualified HALT, then back-to-back HALT words during and after the pulse.
        drive(0, 1, 0, 1, HALT);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 1, HALT);
        drive(0, 1, 0, 1, NOP);

        // Warm reboot: one-cycle bios_req in MEMORY, then held bios_req during the pulse.
        drive(0, 1, 1, 0, NOP);
        for (int i = 0; i < 2; i++) drive(0, 1, 1, 0, NOP);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, NOP);

        // Reset in the second cycle of PULSE_MEM aborts the handoff.
        drive(0, 1, 0, 1, HALT);
        drive(0, 1, 0, 0, NOP);
        drive(1, 1, 0, 0, NOP);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, NOP);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            opc = ($urandom_range(0, 3) == 0) ? HALT : 6'($urandom);
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, opc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
